// File: rtl/sdp_ram_pipe_if.sv
// sdp_ram_pipe_if: write/read port bundle for sdp_ram_pipe.
//   addra/dina/wea   write port (byte-lane enables)
//   rd_req/addrb     read request and address
//   doutb            read data, valid when doutb_valid is high
//   doutb_valid      one-cycle response strobe
//   collision        response hit a same-cycle write to the same address
//   busy             post-reset clear sequence running
// master: the client driving the RAM; slave: the RAM itself.
interface sdp_ram_pipe_if #(
    parameter int DEPTH     = 8,
    parameter int DATA_SIZE = 32
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]          addra;
    logic [DATA_SIZE-1:0]   dina;
    logic [DATA_SIZE/8-1:0] wea;
    logic                   rd_req;
    logic [AW-1:0]          addrb;
    logic [DATA_SIZE-1:0]   doutb;
    logic                   doutb_valid;
    logic                   collision;
    logic                   busy;

    modport master (
        output addra, dina, wea, rd_req, addrb,
        input  doutb, doutb_valid, collision, busy
    );

    modport slave (
        input  addra, dina, wea, rd_req, addrb,
        output doutb, doutb_valid, collision, busy
    );
endinterface

// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: parametrised simple-dual-port RAM, behavioural inference.
// Byte-lane writes, read latency 1 or 2, same-cycle write/read collision
// handling (write-first byte merge or read-first), and a clear sequence
// that zeroes the array after every reset.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  sdp_ram_pipe_if.slave (write port, read port, busy)
//
// state   | meaning
// S_CLEAR | writing zero to mem[cnt], busy=1, client traffic ignored
// S_READY | normal read/write operation
module sdp_ram_pipe #(
    parameter int DEPTH        = 8,
    parameter int DATA_SIZE    = 32,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1
) (
    input logic          clk,
    input logic          rst,
    sdp_ram_pipe_if.slave bus
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int NB = DATA_SIZE / 8;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t state, state_nx;
    logic [AW-1:0] cnt;
    logic          clr_we;
    logic          clr_en;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    logic                 ready, wr_ok, rd_fire, rd_in, coll_hit;
    logic [AW-1:0]        rd_addr;
    logic [DATA_SIZE-1:0] old_word, rd_word;

    logic                 s1_valid, s1_coll;
    logic [DATA_SIZE-1:0] s1_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (clr_we) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        clr_we   = 1'b0;
        case (state)
            S_CLEAR: begin
                clr_we = 1'b1;
                if (cnt == LAST) state_nx = S_READY;
            end
            S_READY: state_nx = S_READY;
        endcase
    end

    // The FSM sits in S_CLEAR while reset is held; keep the array untouched
    // until reset is actually released.
    assign clr_en = clr_we & rst;

    assign ready    = (state == S_READY);
    assign wr_ok    = ready && (bus.wea != '0) && ({1'b0, bus.addra} < DEPTH_W);
    assign rd_fire  = ready && bus.rd_req;
    assign rd_in    = ({1'b0, bus.addrb} < DEPTH_W);
    assign rd_addr  = rd_in ? bus.addrb : '0;
    // wr_ok already bounds addra, so equality implies an in-range read.
    assign coll_hit = rd_fire && wr_ok && (bus.addra == bus.addrb);

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++)
                if (bus.wea[i]) mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
        end
    end

    always_comb begin
        old_word = mem[rd_addr];
        rd_word  = '0;
        if (rd_in) begin
            for (int i = 0; i < NB; i++)
                rd_word[8*i +: 8] = (BYPASS != 0 && coll_hit && bus.wea[i])
                                    ? bus.dina[8*i +: 8] : old_word[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_coll  <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            s1_coll  <= coll_hit;
            if (rd_fire) s1_data <= rd_word;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                 s2_valid, s2_coll;
            logic [DATA_SIZE-1:0] s2_data;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s2_valid <= 1'b0;
                    s2_coll  <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_coll  <= s1_coll;
                    if (s1_valid) s2_data <= s1_data;
                end
            end

            assign bus.doutb       = s2_data;
            assign bus.doutb_valid = s2_valid;
            assign bus.collision   = s2_coll;
        end else begin : g_lat1
            assign bus.doutb       = s1_data;
            assign bus.doutb_valid = s1_valid;
            assign bus.collision   = s1_coll;
        end
    endgenerate

    assign bus.busy = (state == S_CLEAR);
endmodule

// File: tb/tb_sdp_ram_pipe.sv
// tb_sdp_ram_pipe: two instances driven with identical stimulus.
//   u_a: DEPTH=8, READ_LATENCY=1, BYPASS=1
//   u_b: DEPTH=6, READ_LATENCY=2, BYPASS=0
module tb_sdp_ram_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  addra, addrb;
    logic [31:0] dina;
    logic [3:0]  wea;
    logic        rd_req;

    int n_vec = 0;
    int n_err = 0;

    logic [2:0]  ba [8];
    logic [31:0] ea [8];
    logic [31:0] eb [8];

    sdp_ram_pipe_if #(.DEPTH(8), .DATA_SIZE(32)) bus_a ();
    sdp_ram_pipe_if #(.DEPTH(6), .DATA_SIZE(32)) bus_b ();

    assign bus_a.addra  = addra;
    assign bus_a.dina   = dina;
    assign bus_a.wea    = wea;
    assign bus_a.rd_req = rd_req;
    assign bus_a.addrb  = addrb;
    assign bus_b.addra  = addra;
    assign bus_b.dina   = dina;
    assign bus_b.wea    = wea;
    assign bus_b.rd_req = rd_req;
    assign bus_b.addrb  = addrb;

    sdp_ram_pipe #(.DEPTH(8), .DATA_SIZE(32), .READ_LATENCY(1), .BYPASS(1))
        u_a (.clk(clk), .rst(rst), .bus(bus_a));
    sdp_ram_pipe #(.DEPTH(6), .DATA_SIZE(32), .READ_LATENCY(2), .BYPASS(0))
        u_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] w);
        addra = a; dina = d; wea = w;
        tick();
        wea = 4'b0;
    endtask

    // Release-to-ready timing, optionally poking write/read traffic during clear.
    task automatic clear_check(input bit poke, input string tag);
        int fa = -1;
        int fb = -1;
        bit sawv = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (poke && k <= 5) begin
                addra = 3'd0; dina = 32'hFFFF_FFFF; wea = 4'hF;
                rd_req = 1'b1; addrb = 3'd0;
            end else begin
                wea = 4'h0; rd_req = 1'b0;
            end
            tick();
            if (!bus_a.busy && fa < 0) fa = k;
            if (!bus_b.busy && fb < 0) fb = k;
            if (bus_a.doutb_valid || bus_b.doutb_valid ||
                bus_a.collision || bus_b.collision) sawv = 1'b1;
        end
        chk({tag, " busyA_cycles"}, fa, 32'd8);
        chk({tag, " busyB_cycles"}, fb, 32'd6);
        chk({tag, " valid_in_clear"}, {31'b0, sawv}, 32'd0);
    endtask

    // Requests ba[0..7] on consecutive edges; A answers one edge later, B two.
    task automatic burst(input string tag);
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                rd_req = 1'b1; addrb = ba[c];
            end else begin
                rd_req = 1'b0;
            end
            tick();
            if (c < 8) begin
                chk($sformatf("%s A valid[%0d]", tag, c), {31'b0, bus_a.doutb_valid}, 32'd1);
                chk($sformatf("%s A data[%0d]", tag, c), bus_a.doutb, ea[c]);
                chk($sformatf("%s A coll[%0d]", tag, c), {31'b0, bus_a.collision}, 32'd0);
            end else begin
                chk($sformatf("%s A idle[%0d]", tag, c), {31'b0, bus_a.doutb_valid}, 32'd0);
            end
            if (c >= 1 && c <= 8) begin
                chk($sformatf("%s B valid[%0d]", tag, c-1), {31'b0, bus_b.doutb_valid}, 32'd1);
                chk($sformatf("%s B data[%0d]", tag, c-1), bus_b.doutb, eb[c-1]);
                chk($sformatf("%s B coll[%0d]", tag, c-1), {31'b0, bus_b.collision}, 32'd0);
            end else begin
                chk($sformatf("%s B idle[%0d]", tag, c), {31'b0, bus_b.doutb_valid}, 32'd0);
            end
        end
    endtask

    initial begin
        addra = '0; addrb = '0; dina = '0; wea = '0; rd_req = 1'b0;
        for (int i = 0; i < 8; i++) ba[i] = 3'(i);

        // reset state
        #1;
        chk("rst A doutb", bus_a.doutb, 32'd0);
        chk("rst A valid", {31'b0, bus_a.doutb_valid}, 32'd0);
        chk("rst A coll", {31'b0, bus_a.collision}, 32'd0);
        chk("rst A busy", {31'b0, bus_a.busy}, 32'd1);
        chk("rst B doutb", bus_b.doutb, 32'd0);
        chk("rst B busy", {31'b0, bus_b.busy}, 32'd1);
        tick();
        tick();
        rst = 1'b1;
        clear_check(1'b1, "clr1");

        // all words zero after clear (writes during clear ignored)
        for (int i = 0; i < 8; i++) begin ea[i] = 32'd0; eb[i] = 32'd0; end
        burst("zero");

        // byte-lane merge
        wr(3'd3, 32'hAABB_CCDD, 4'b1111);
        wr(3'd3, 32'h1122_3344, 4'b0010);
        rd_req = 1'b1; addrb = 3'd3;
        tick();
        rd_req = 1'b0;
        chk("merge A valid", {31'b0, bus_a.doutb_valid}, 32'd1);
        chk("merge A data", bus_a.doutb, 32'hAABB_33DD);
        chk("merge A coll", {31'b0, bus_a.collision}, 32'd0);
        chk("merge B early", {31'b0, bus_b.doutb_valid}, 32'd0);
        tick();
        chk("merge A drop", {31'b0, bus_a.doutb_valid}, 32'd0);
        chk("merge A hold", bus_a.doutb, 32'hAABB_33DD);
        chk("merge B valid", {31'b0, bus_b.doutb_valid}, 32'd1);
        chk("merge B data", bus_b.doutb, 32'hAABB_33DD);
        chk("merge B coll", {31'b0, bus_b.collision}, 32'd0);
        tick();
        chk("merge B drop", {31'b0, bus_b.doutb_valid}, 32'd0);

        // collision: A write-first merge, B read-first
        wr(3'd5, 32'h0102_0304, 4'hF);
        addra = 3'd5; dina = 32'hFFFF_FFFF; wea = 4'b0101;
        rd_req = 1'b1; addrb = 3'd5;
        tick();
        wea = 4'h0; rd_req = 1'b0;
        chk("coll A valid", {31'b0, bus_a.doutb_valid}, 32'd1);
        chk("coll A data", bus_a.doutb, 32'h01FF_03FF);
        chk("coll A flag", {31'b0, bus_a.collision}, 32'd1);
        tick();
        chk("coll A flag clr", {31'b0, bus_a.collision}, 32'd0);
        chk("coll B valid", {31'b0, bus_b.doutb_valid}, 32'd1);
        chk("coll B data", bus_b.doutb, 32'h0102_0304);
        chk("coll B flag", {31'b0, bus_b.collision}, 32'd1);
        rd_req = 1'b1; addrb = 3'd5;
        tick();
        rd_req = 1'b0;
        chk("coll B flag clr", {31'b0, bus_b.collision}, 32'd0);
        chk("reread A data", bus_a.doutb, 32'h01FF_03FF);
        chk("reread A coll", {31'b0, bus_a.collision}, 32'd0);
        tick();
        chk("reread B valid", {31'b0, bus_b.doutb_valid}, 32'd1);
        chk("reread B data", bus_b.doutb, 32'h01FF_03FF);

        // write one edge after a read must not change that read's data
        rd_req = 1'b1; addrb = 3'd3;
        tick();
        rd_req = 1'b0;
        chk("late A data", bus_a.doutb, 32'hAABB_33DD);
        addra = 3'd3; dina = 32'h5555_5555; wea = 4'hF;
        tick();
        wea = 4'h0;
        chk("late B valid", {31'b0, bus_b.doutb_valid}, 32'd1);
        chk("late B data", bus_b.doutb, 32'hAABB_33DD);

        // preload and back-to-back stream; B drops addresses 6 and 7
        for (int i = 0; i < 8; i++) wr(3'(i), 32'h100 + 32'(i), 4'hF);
        wr(3'd7, 32'hDEAD_BEEF, 4'hF);
        for (int i = 0; i < 8; i++) begin
            ea[i] = 32'h100 + 32'(i);
            eb[i] = (i < 6) ? 32'h100 + 32'(i) : 32'd0;
        end
        ea[7] = 32'hDEAD_BEEF;
        burst("stream");

        // reset with reads in flight
        rd_req = 1'b1; addrb = 3'd1;
        tick();
        addrb = 3'd2;
        tick();
        rd_req = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid A doutb", bus_a.doutb, 32'd0);
        chk("mid A valid", {31'b0, bus_a.doutb_valid}, 32'd0);
        chk("mid B doutb", bus_b.doutb, 32'd0);
        chk("mid B valid", {31'b0, bus_b.doutb_valid}, 32'd0);
        chk("mid A busy", {31'b0, bus_a.busy}, 32'd1);
        tick();
        tick();
        chk("mid B stale", {31'b0, bus_b.doutb_valid}, 32'd0);
        rst = 1'b1;
        clear_check(1'b0, "clr2");
        for (int i = 0; i < 8; i++) begin ea[i] = 32'd0; eb[i] = 32'd0; end
        burst("zero2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sdp_ram_pipe.md
Name: sdp_ram_pipe

Overview:
Parametrised simple-dual-port RAM, the successor to the fixed 32-bit memory wrapper. It uses behavioural inference with no vendor macro. Features: generic byte-lane write width, selectable read latency of 1 or 2, read-request/valid tracking, and same-cycle write/read collision forwarding with byte merge. A self-clear sequencer zeroes the array after every reset, so DMA buffers start from known contents.

Parameters:
DEPTH, 8, number of words; any value >= 2, need not be a power of 2
DATA_SIZE, 32, word width in bits; multiple of 8
READ_LATENCY, 1, request-to-data cycles; legal values 1 or 2
BYPASS, 1, collision mode: 1 = forward new bytes (write-first), 0 = return old word (read-first)

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  reset, asynchronous, active-low
addra  input  AW=max(1,$clog2(DEPTH))  write address
dina  input  DATA_SIZE  write data
wea  input  DATA_SIZE/8  per-byte write enable; bit i controls dina[8i+7:8i]
rd_req  input  1  read request, samples addrb
addrb  input  AW  read address
doutb  output  DATA_SIZE  read data
doutb_valid  output  1  one-cycle strobe, doutb carries requested word
collision  output  1  aligned with doutb_valid; request hit a same-cycle write to the same address
busy  output  1  clear sequence in progress; writes/reads ignored

Behaviour:
- Reset (rst=0, async):
  - doutb=0, doutb_valid=0, collision=0, busy=1.
  - Read pipeline flushed; clear counter=0; FSM -> CLEAR.
  - Array contents untouched until CLEAR runs.
- FSM CLEAR:
  - From the first rising edge with rst=1, writes zero to address cnt and increments cnt each cycle.
  - The edge that writes DEPTH-1 moves the FSM to READY; busy=0 from that edge on.
  - busy is therefore high for exactly DEPTH cycles after reset release.
  - In CLEAR, wea and rd_req are ignored: no write, no valid, no collision.
- FSM READY:
  - Write: at each edge, for every i with wea[i]=1 and addra<DEPTH, mem[addra] byte i <= dina byte i.
  - wea=0 means no write. addra>=DEPTH drops the write silently.
  - Read: rd_req=1 at edge N samples addrb. doutb/doutb_valid update at edge N+READ_LATENCY.
  - doutb holds its last value when doutb_valid=0.
  - A request every cycle gives a continuous valid stream, in order, with no bubbles.
  - addrb>=DEPTH returns 0 with doutb_valid=1, collision=0.
- Collision: rd_req=1, wea!=0, addra==addrb<DEPTH at the same edge.
  - BYPASS=1: returned word per byte = dina byte if wea[i] else old mem byte.
  - BYPASS=0: returned word = old mem word.
  - Either mode: array updated normally; collision=1 with that response's doutb_valid.
- READ_LATENCY=2:
  - Word captured from the array (plus merge) in stage 1; stage 2 is a pure register.
  - A write at edge N+1 to the address read at N does not alter the response.
- Reset mid-operation: in-flight reads are discarded, never emitted. CLEAR restarts from address 0.
- No other internal state; no back-pressure on the read port.

Test Plan:
1. DEPTH=8, release rst -> busy=1 for exactly 8 clk, then 0; read addrs 0..7 -> all 0x00000000, valid each.
2. Write 0xAABBCCDD wea=4'b1111 addr 3, then 0x11223344 wea=4'b0010 addr 3; rd_req addr 3 at edge N -> doutb=0xAABB33DD. Valid at N+1 (READ_LATENCY=1) / N+2 (READ_LATENCY=2); collision=0.
3. mem[5]=0x01020304; same edge write 0xFFFFFFFF wea=4'b0101 addr 5 and rd_req addr 5 -> BYPASS=1: doutb=0x01FF03FF collision=1; BYPASS=0: doutb=0x01020304 collision=1. Later read of 5 -> 0x01FF03FF in both modes.
4. Preload mem[i]=i+0x100; rd_req=1 for 8 consecutive cycles, addrs 0..7 -> doutb_valid high 8 consecutive cycles, data 0x100..0x107 in order.
5. Two reads in flight (READ_LATENCY=2), assert rst -> doutb=0, doutb_valid=0 with no clock edge. After release, no stale valid; busy for DEPTH cycles; earlier data reads back 0.
6. DEPTH=6: write 0xDEADBEEF addr 7; read addr 7 -> 0 with valid; read addrs 0..5 unchanged; busy lasts 6 cycles after reset.
